decode_hazard_unit: RTL

- Decode-side producer of the ID/EX stall/squash controls (stall_decode, flush_decode, pc_hold).
- Keeps an internal 3-deep scoreboard that shadows the EX/MEM/WB destination registers, so it needs only ID-stage inputs plus global freeze/redirect.
- Detects RAW hazards against the instruction in ID and sequences SIIC/RTI squashes.
- Sits between IF/ID and the ID/EX pipe register.

---
 rtl/decode_hazard_unit_if.sv | 41 ++++
 rtl/decode_hazard_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/decode_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// decode_hazard_unit_if
//   Bundles the ID-stage inputs, the global freeze/redirect controls and the
//   stall/squash outputs of decode_hazard_unit.
//   master : pipeline side (drives the ID instruction fields, mem_stall and
//            ex_redirect; observes the controls)
//   slave  : decode_hazard_unit
//   Param CNT_W : width of stall_count
// ---------------------------------------------------------------------------
interface decode_hazard_unit_if #(
  parameter int CNT_W = 8
);
  logic             id_valid;
  logic [4:0]       id_opcode;
  logic [2:0]       id_rs;
  logic             id_rs_valid;
  logic [2:0]       id_rt;
  logic             id_rt_valid;
  logic [2:0]       id_write_sel;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             mem_stall;
  logic             ex_redirect;
  logic             stall_decode;
  logic             flush_decode;
  logic             pc_hold;
  logic             trap_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_opcode, id_rs, id_rs_valid, id_rt, id_rt_valid,
           id_write_sel, id_reg_write, id_mem_read, mem_stall, ex_redirect,
    input  stall_decode, flush_decode, pc_hold, trap_busy, stall_count
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rs_valid, id_rt, id_rt_valid,
           id_write_sel, id_reg_write, id_mem_read, mem_stall, ex_redirect,
    output stall_decode, flush_decode, pc_hold, trap_busy, stall_count
  );
endinterface

// File: rtl/decode_hazard_unit.sv
// ---------------------------------------------------------------------------
// decode_hazard_unit
//   Decode-side stall/squash control. A 3-deep scoreboard shadows the
//   destination registers of the instructions in EX/MEM/WB so RAW hazards can
//   be detected from ID-stage information alone. A small trap FSM squashes
//   IF/ID for SIIC/RTI and waits for the pipe to drain before issue resumes.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-low reset
//     bus  : decode_hazard_unit_if.slave (ID fields, mem_stall, ex_redirect,
//            stall_decode, flush_decode, pc_hold, trap_busy, stall_count)
//   Params:
//     FORWARDING : 1 = only load-use stalls; 0 = stall on any EX/MEM match
//     CNT_W      : width of the saturating stall counter
// ---------------------------------------------------------------------------
module decode_hazard_unit #(
  parameter int FORWARDING = 1,
  parameter int CNT_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  decode_hazard_unit_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [2:0] rg;
    logic       load;
  } sb_t;

  typedef enum logic [1:0] {S_IDLE, S_SQUASH, S_DRAIN} state_t;

  sb_t        r_sb_ex, r_sb_mem, r_sb_wb;
  state_t     r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_match_ex, w_match_mem, w_hazard;
  logic w_stall, w_flush, w_issue, w_trap_op, w_sb_empty;

  function automatic logic f_match(input sb_t e, input logic [2:0] rs,
                                   input logic rsv, input logic [2:0] rt,
                                   input logic rtv);
    return e.valid & ((rsv & (rs == e.rg)) | (rtv & (rt == e.rg)));
  endfunction

  assign w_match_ex  = f_match(r_sb_ex,  bus.id_rs, bus.id_rs_valid,
                               bus.id_rt, bus.id_rt_valid);
  assign w_match_mem = f_match(r_sb_mem, bus.id_rs, bus.id_rs_valid,
                               bus.id_rt, bus.id_rt_valid);

  // WB is never checked: the regfile writes before it is read.
  if (FORWARDING != 0) begin : g_fwd
    assign w_hazard = w_match_ex & r_sb_ex.load;
  end else begin : g_nofwd
    assign w_hazard = w_match_ex | w_match_mem;
  end

  assign w_stall    = bus.id_valid & w_hazard & ~bus.ex_redirect & (r_state == S_IDLE);
  assign w_flush    = bus.ex_redirect | (r_state == S_SQUASH);
  // Nothing issues while the trap sequence drains the pipe.
  assign w_issue    = bus.id_valid & ~w_stall & ~w_flush & ~bus.mem_stall &
                      (r_state != S_DRAIN);
  assign w_trap_op  = (bus.id_opcode == 5'b00010) | (bus.id_opcode == 5'b00011);
  assign w_sb_empty = ~r_sb_ex.valid & ~r_sb_mem.valid & ~r_sb_wb.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_ex  <= '0;
      r_sb_mem <= '0;
      r_sb_wb  <= '0;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
    end else if (!bus.mem_stall) begin
      r_sb_wb  <= r_sb_mem;
      r_sb_mem <= r_sb_ex;
      r_sb_ex  <= '{valid: w_issue & bus.id_reg_write,
                    rg:    bus.id_write_sel,
                    load:  bus.id_mem_read};
      if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE:   if (w_issue && w_trap_op) r_state <= S_SQUASH;
        S_SQUASH: r_state <= S_DRAIN;
        S_DRAIN:  if (w_sb_empty) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_decode = w_stall;
  assign bus.flush_decode = w_flush;
  assign bus.pc_hold      = w_stall | bus.mem_stall;
  assign bus.trap_busy    = (r_state != S_IDLE);
  assign bus.stall_count  = r_cnt;

endmodule
